fir_lms_engine: RTL and testbench

- Adaptive FIR responder on the core's `fir_go`/`fir_done` handshake.
- Per request:
  - accepts the core's feedforward sample and weight-adjust term;
  - shifts the sample into a TAPS-deep delay line;
  - computes the filter output with one MAC per cycle;
  - applies an LMS weight update to every tap in the same pass;
  - returns the result with a single-cycle `fir_done` pulse.
- Sits between `core` and the output path; it is the only block that owns tap weights and delay-line state.

---
 rtl/fir_lms_engine.sv | 108 ++++++++++
 tb/tb_fir_lms_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fir_lms_engine.sv
// Adaptive FIR responder: shifts a new sample into the delay line, runs one MAC
// per tap while applying an LMS weight update, then pulses fir_done with the result.
module fir_lms_engine #(
  parameter int TAPS = 16,
  parameter int FRAC = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fir_go,
  input  logic signed [31:0] feedforward_in,
  input  logic signed [31:0] weight_adjust,
  output logic               fir_done,
  output logic signed [31:0] fir_out
);

  localparam int IDX_W = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nxt;

  logic signed [15:0] x [TAPS];
  logic signed [15:0] w [TAPS];
  logic signed [15:0] step;
  logic signed [47:0] acc;
  logic [IDX_W-1:0]   idx;

  logic               last_tap;
  logic signed [15:0] x_cur, w_cur;
  logic signed [31:0] prod_acc, prod_upd, upd_shift, upd_sum, step_raw;
  logic signed [47:0] acc_shift;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7fff;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [47:0] v);
    if (v > 48'sd2147483647)       return 32'sh7fff_ffff;
    else if (v < -48'sd2147483648) return 32'sh8000_0000;
    else                           return v[31:0];
  endfunction

  assign last_tap  = (idx == IDX_W'(TAPS - 1));
  assign x_cur     = x[idx];
  assign w_cur     = w[idx];
  assign prod_acc  = 32'(w_cur) * 32'(x_cur);
  assign prod_upd  = 32'(step) * 32'(x_cur);
  assign upd_shift = prod_upd >>> FRAC;
  assign upd_sum   = 32'(w_cur) + upd_shift;
  assign step_raw  = weight_adjust >>> FRAC;
  assign acc_shift = acc >>> FRAC;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fir_go) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        w[i] <= '0;
      end
      step     <= '0;
      acc      <= '0;
      idx      <= '0;
      fir_done <= 1'b0;
      fir_out  <= '0;
    end else begin
      fir_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fir_go) begin
            for (int unsigned i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
            x[0] <= feedforward_in[15:0];
            step <= sat16(step_raw);
            acc  <= '0;
            idx  <= '0;
          end
        end
        MAC: begin
          // Accumulate with the pre-update weight; the write-back lands at the same edge.
          acc    <= acc + 48'(prod_acc);
          w[idx] <= sat16(upd_sum);
          idx    <= last_tap ? '0 : idx + IDX_W'(1);
        end
        DONE: begin
          fir_out  <= sat32(acc_shift);
          fir_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_lms_engine.sv
// Directed and randomized checks of fir_lms_engine against an array-based
// reference of the adaptive filter arithmetic.
module tb_fir_lms_engine;
  localparam int TAPS = 16;
  localparam int FRAC = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fir_go = 1'b0;
  logic signed [31:0] feedforward_in = '0;
  logic signed [31:0] weight_adjust = '0;
  logic               fir_done;
  logic signed [31:0] fir_out;

  fir_lms_engine #(.TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk(clk),
    .rst(rst),
    .fir_go(fir_go),
    .feedforward_in(feedforward_in),
    .weight_adjust(weight_adjust),
    .fir_done(fir_done),
    .fir_out(fir_out)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_done = 0;
  longint mx [TAPS];
  longint mw [TAPS];
  longint prev_out = 0;

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = 0;
      mw[i] = 0;
    end
    prev_out = 0;
  endtask

  task automatic model_req(input logic [31:0] ff, input logic [31:0] wa, output longint res);
    logic signed [15:0] s16;
    longint step, acc;
    s16 = ff[15:0];
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = longint'(s16);
    step = clamp(longint'($signed(wa)) >>> FRAC, -32768, 32767);
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      acc   = acc + mw[i] * mx[i];
      mw[i] = clamp(mw[i] + ((step * mx[i]) >>> FRAC), -32768, 32767);
    end
    res = clamp(acc >>> FRAC, -64'sd2147483648, 64'sd2147483647);
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_done", fir_done, 0);
    check("rst_out", fir_out, 0);
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Drives fir_go so it is sampled at the next edge (E0) and returns just after E_{TAPS+1}.
  task automatic do_req(input logic [31:0] ff, input logic [31:0] wa, input bit go_mid);
    longint exp;
    model_req(ff, wa, exp);
    fir_go = 1'b1;
    feedforward_in = ff;
    weight_adjust = wa;
    tick();
    fir_go = 1'b0;
    feedforward_in = $urandom;
    weight_adjust = $urandom;
    check("done_low_e0", fir_done, 0);
    for (int k = 1; k <= TAPS; k++) begin
      if (go_mid && k == 5) fir_go = 1'b1;
      tick();
      fir_go = 1'b0;
      check("done_low_mac", fir_done, 0);
      check("out_hold", fir_out, prev_out);
    end
    tick();
    check("done_pulse", fir_done, 1);
    check("fir_out", fir_out, exp);
    if (fir_done) n_done++;
    prev_out = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    // Latency, ignored mid-MAC request, LMS first step.
    do_req(32'd16384, 32'h2000_0000, 1'b1);
    check("lms1_out", fir_out, 0);
    check("lms1_w0", dut.w[0], 8192);
    tick();
    check("done_drop", fir_done, 0);
    for (int k = 0; k < TAPS + 2; k++) begin
      tick();
      check("no_extra_done", fir_done, 0);
    end
    do_req(32'd16384, 32'd0, 1'b0);
    check("lms2_out", fir_out, 4096);

    do_reset();
    do_req(32'hFFFF_C000, 32'h2000_0000, 1'b0);
    check("neg_w0", dut.w[0], -8192);
    do_req(32'd16384, 32'd0, 1'b0);
    check("neg_out", fir_out, -4096);

    do_reset();
    do_req(32'd32767, 32'h7FFF_FFFF, 1'b0);
    check("sat1_w0", dut.w[0], 32766);
    do_req(32'd32767, 32'h7FFF_FFFF, 1'b0);
    check("sat2_w0", dut.w[0], 32767);
    check("sat2_w1", dut.w[1], 32766);

    // Reset in the middle of a computation.
    tick();
    fir_go = 1'b1;
    feedforward_in = 32'd12345;
    weight_adjust = 32'h1000_0000;
    tick();
    fir_go = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("midrst_done", fir_done, 0);
      check("midrst_out", fir_out, 0);
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < TAPS + 4; k++) begin
      tick();
      check("abort_no_done", fir_done, 0);
    end
    do_req(32'd100, 32'd0, 1'b0);
    check("post_rst_out", fir_out, 0);

    // Back-to-back randomized requests, past delay-line wrap.
    n_done = 0;
    for (int r = 0; r < 20; r++) begin
      logic [31:0] wa;
      wa = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom) >>> $urandom_range(2, 8));
      do_req($urandom, wa, 1'b0);
    end
    check("b2b_count", n_done, 20);
    for (int i = 0; i < TAPS; i++) check("b2b_weight", dut.w[i], mw[i]);
    tick();
    check("b2b_done_drop", fir_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
